screen_sequencer: RTL and testbench

- Top-level game/screen controller for the slime-games VGA design.
- Converts USB keyboard keycodes and scoring pulses into the one-hot screen-select flags consumed by the colour mapper: MainS, StartScreen, Instructions, PauseScreen1/2, Game1Screen, Game2Screen, ExitScreen, plus Ready.
- Owns the per-game score counters.
- All screen changes are committed only on a frame tick, so the raster never switches screens mid-frame.

---
 rtl/slime_pkg.sv | 18 +
 rtl/screen_sequencer_if.sv | 20 ++
 rtl/frame_tick_sync.sv | 17 +
 rtl/screen_sequencer.sv | 113 +++++++++++
 tb/tb_screen_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/slime_pkg.sv
// slime_pkg: screen states, keycodes and winner encodings shared by screen_sequencer.
package slime_pkg;
  typedef enum logic [2:0] {MAIN, INSTR, START, GAME1, GAME2, PAUSE1, PAUSE2, EXIT} screen_t;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;
  localparam logic [7:0] KEY_I     = 8'h0C;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_ONE   = 8'h1E;
  localparam logic [7:0] KEY_TWO   = 8'h1F;
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;
  // One-hot flag vector ordered like screen_t, MAIN in the MSB.
  function automatic logic [7:0] screen_flags(screen_t s);
    return 8'h80 >> s;
  endfunction
endpackage

// File: rtl/screen_sequencer_if.sv
// screen_sequencer_if: keyboard/score inputs and screen-select/score outputs of screen_sequencer.
interface screen_sequencer_if;
  logic [7:0] keycode;
  logic       score_p1, score_p2;
  logic       MainS, StartScreen, Instructions, PauseScreen1, PauseScreen2;
  logic       Game1Screen, Game2Screen, ExitScreen;
  logic       Ready, game_rst;
  logic [3:0] Score1, Score2;
  logic [1:0] winner;
  modport master (
    output keycode, score_p1, score_p2,
    input  MainS, StartScreen, Instructions, PauseScreen1, PauseScreen2,
    input  Game1Screen, Game2Screen, ExitScreen, Ready, game_rst, Score1, Score2, winner
  );
  modport slave (
    input  keycode, score_p1, score_p2,
    output MainS, StartScreen, Instructions, PauseScreen1, PauseScreen2,
    output Game1Screen, Game2Screen, ExitScreen, Ready, game_rst, Score1, Score2, winner
  );
endinterface

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings vsync into the Clk domain and emits one registered Clk pulse per rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);
  logic [2:0] sync;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      sync       <= '0;
      frame_tick <= 1'b0;
    end else begin
      sync       <= {sync[1:0], frame_clk};
      frame_tick <= sync[1] & ~sync[2];
    end
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-synchronous screen FSM and score keeper for the slime-games VGA design.
// Define SCREEN_EXIT_TIMEOUT_EN to let the exit screen fall back to MAIN after EXIT_FRAMES ticks.
module screen_sequencer
  import slime_pkg::*;
#(
  parameter int READY_FRAMES = 120,
  parameter int WIN_SCORE    = 7,
  parameter int EXIT_FRAMES  = 300
) (
  input logic Clk,
  input logic Reset_n,
  input logic frame_clk,
  screen_sequencer_if.slave bus
);
  // Counter is shared by the game countdown and the optional exit timeout.
  localparam int CW = $clog2((READY_FRAMES > EXIT_FRAMES ? READY_FRAMES : EXIT_FRAMES) + 1);
  localparam logic [CW-1:0] READY_CNT = CW'(READY_FRAMES);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
`ifdef SCREEN_EXIT_TIMEOUT_EN
  localparam logic [CW-1:0] EXIT_CNT = CW'(EXIT_FRAMES);
`endif
  screen_t state, state_n;
  logic frame_tick, key_evt, point, entry, win_hit, in_game, ready, game_rst;
  logic [7:0] key_prev, pend_key, key, flags_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] score1, score2, score1_n, score2_n;
  logic [1:0] winner, winner_n;

  frame_tick_sync u_sync (.Clk, .Reset_n, .frame_clk, .frame_tick);

  assign key_evt = bus.keycode != 8'h00 && bus.keycode != key_prev;
  // A key pressed on the tick itself still counts when nothing was pending.
  assign key     = !frame_tick ? 8'h00 : pend_key != 8'h00 ? pend_key : key_evt ? bus.keycode : 8'h00;
  assign in_game = state == GAME1 || state == GAME2;
  assign point   = in_game && ready && (bus.score_p1 || bus.score_p2);
  assign win_hit = score1 == WIN || score2 == WIN;

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= MAIN;
    else state <= state_n;

  always_comb begin
    state_n = state;
    if (frame_tick)
      case (state)
        MAIN:   state_n = key == KEY_ENTER ? START : key == KEY_I ? INSTR : MAIN;
        INSTR:  state_n = key == KEY_ESC ? MAIN : INSTR;
        START:  state_n = key == KEY_ONE ? GAME1 : key == KEY_TWO ? GAME2 : key == KEY_ESC ? MAIN : START;
        GAME1:  state_n = win_hit ? EXIT : key == KEY_ESC ? MAIN : key == KEY_P ? PAUSE1 : GAME1;
        GAME2:  state_n = win_hit ? EXIT : key == KEY_ESC ? MAIN : key == KEY_P ? PAUSE2 : GAME2;
        PAUSE1: state_n = win_hit ? EXIT : key == KEY_ESC ? MAIN : key == KEY_P ? GAME1 : PAUSE1;
        PAUSE2: state_n = win_hit ? EXIT : key == KEY_ESC ? MAIN : key == KEY_P ? GAME2 : PAUSE2;
`ifdef SCREEN_EXIT_TIMEOUT_EN
        EXIT:   state_n = key == KEY_ENTER || cnt < CW'(2) ? MAIN : EXIT;
`else
        EXIT:   state_n = key == KEY_ENTER ? MAIN : EXIT;
`endif
        default: state_n = MAIN;
      endcase
  end

  always_comb begin
    entry    = state == START && (state_n == GAME1 || state_n == GAME2);
    score1_n = entry ? 4'd0 : point && bus.score_p1 && score1 != WIN ? score1 + 4'd1 : score1;
    score2_n = entry ? 4'd0 : point && bus.score_p2 && score2 != WIN ? score2 + 4'd1 : score2;
    winner_n = entry ? WIN_NONE : state_n == EXIT && state != EXIT ?
               (score1 == WIN ? WIN_P1 : WIN_NONE) | (score2 == WIN ? WIN_P2 : WIN_NONE) : winner;
`ifdef SCREEN_EXIT_TIMEOUT_EN
    cnt_n    = entry || point ? READY_CNT : state_n == EXIT && state != EXIT ? EXIT_CNT :
               frame_tick && (in_game || state == EXIT) && cnt != '0 ? cnt - CW'(1) : cnt;
`else
    cnt_n    = entry || point ? READY_CNT : frame_tick && in_game && cnt != '0 ? cnt - CW'(1) : cnt;
`endif
  end

  // Pause freezes cnt, so Ready on return is simply whether the countdown had finished.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      key_prev <= '0;
      pend_key <= '0;
      cnt      <= '0;
      score1   <= '0;
      score2   <= '0;
      winner   <= WIN_NONE;
      ready    <= 1'b0;
      game_rst <= 1'b0;
      flags_q  <= screen_flags(MAIN);
    end else begin
      key_prev <= bus.keycode;
      pend_key <= frame_tick ? 8'h00 : pend_key == 8'h00 && key_evt ? bus.keycode : pend_key;
      cnt      <= cnt_n;
      score1   <= score1_n;
      score2   <= score2_n;
      winner   <= winner_n;
      ready    <= (state_n == GAME1 || state_n == GAME2) && cnt_n == '0;
      game_rst <= entry || point;
      flags_q  <= screen_flags(state_n);
    end

  assign bus.MainS        = flags_q[7];
  assign bus.Instructions = flags_q[6];
  assign bus.StartScreen  = flags_q[5];
  assign bus.Game1Screen  = flags_q[4];
  assign bus.Game2Screen  = flags_q[3];
  assign bus.PauseScreen1 = flags_q[2];
  assign bus.PauseScreen2 = flags_q[1];
  assign bus.ExitScreen   = flags_q[0];
  assign bus.Ready        = ready;
  assign bus.game_rst     = game_rst;
  assign bus.Score1       = score1;
  assign bus.Score2       = score2;
  assign bus.winner       = winner;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: scoreboard bench for screen_sequencer driven by directed key and score vectors.
module tb_screen_sequencer;
  typedef logic [19:0] obs_t;
  localparam logic [7:0] F_MAIN = 8'h80, F_START = 8'h40, F_INSTR = 8'h20, F_P1 = 8'h10;
  localparam logic [7:0] F_G1 = 8'h04, F_G2 = 8'h02, F_EXIT = 8'h01;
  localparam logic [7:0] K_ENTER = 8'h28, K_ESC = 8'h29, K_I = 8'h0C, K_P = 8'h13, K_ONE = 8'h1E, K_TWO = 8'h1F;

  logic Clk = 1'b0, Reset_n = 1'b1, frame_clk = 1'b0;
  int checks = 0, errors = 0;
  obs_t exp_q[$];
  obs_t prev = 20'h80000;

  screen_sequencer_if bus ();
  screen_sequencer dut (.Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .bus(bus));

  always #5 Clk = ~Clk;
  initial begin
    #3;
    forever #60 frame_clk = ~frame_clk;
  end

  function automatic logic [7:0] cur_flags();
    return {bus.MainS, bus.StartScreen, bus.Instructions, bus.PauseScreen1, bus.PauseScreen2,
            bus.Game1Screen, bus.Game2Screen, bus.ExitScreen};
  endfunction
  function automatic obs_t sample();
    return {cur_flags(), bus.Ready, bus.game_rst, bus.Score1, bus.Score2, bus.winner};
  endfunction

  task automatic push(logic [7:0] f, logic r, logic g, logic [3:0] a, logic [3:0] b, logic [1:0] w);
    exp_q.push_back({f, r, g, a, b, w});
  endtask
  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, want);
    end
  endtask
  task automatic settle_tick();
    @(posedge frame_clk);
    repeat (5) @(posedge Clk);
    #1;
  endtask
  task automatic press(logic [7:0] k, int n);
    @(negedge Clk) bus.keycode = k;
    repeat (n) settle_tick();
    @(negedge Clk) bus.keycode = 8'h00;
  endtask
  task automatic pulse(logic a, logic b);
    @(negedge Clk);
    bus.score_p1 = a;
    bus.score_p2 = b;
    @(negedge Clk);
    bus.score_p1 = 1'b0;
    bus.score_p2 = 1'b0;
  endtask
  task automatic wait_for(string nm, logic [7:0] f, logic r, int lim);
    for (int i = 0; i < lim && !(cur_flags() === f && bus.Ready === r); i++) @(negedge Clk);
    check(nm, 32'({cur_flags(), bus.Ready}), 32'({f, r}));
  endtask

  // Monitor: every change of the observed outputs must match the next queued expectation.
  always @(negedge Clk) begin
    obs_t cur, e;
    cur = sample();
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got %h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL event got %h expected %h", cur, e);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.keycode = 8'h00;
    bus.score_p1 = 1'b0;
    bus.score_p2 = 1'b0;
    #2 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_state", 32'(sample()), 32'h80000);
    Reset_n = 1'b1;
    // MAIN -> START -> GAME1 with the 120-tick countdown
    push(F_START, 0, 0, 0, 0, 0);
    press(K_ENTER, 5);
    wait_for("start", F_START, 0, 20);
    push(F_G1, 0, 1, 0, 0, 0);
    push(F_G1, 0, 0, 0, 0, 0);
    push(F_G1, 1, 0, 0, 0, 0);
    @(negedge Clk) bus.keycode = K_ONE;
    wait_for("enter_game1", F_G1, 0, 100);
    n = 0;
    while (bus.Ready !== 1'b1 && n < 200) begin
      settle_tick();
      n++;
    end
    check("ready_ticks", 32'(n), 32'd120);
    @(negedge Clk) bus.keycode = 8'h00;
    // pause and resume without reloading the countdown
    push(F_P1, 0, 0, 0, 0, 0);
    press(K_P, 10);
    check("pause_onehot", 32'(cur_flags()), 32'(F_P1));
    push(F_G1, 1, 0, 0, 0, 0);
    press(K_P, 1);
    repeat (3) settle_tick();
    check("resume_ready", 32'(bus.Ready), 32'd1);
    push(F_MAIN, 0, 0, 0, 0, 0);
    press(K_ESC, 1);
    // GAME2: player 2 wins 7-0
    push(F_START, 0, 0, 0, 0, 0);
    press(K_ENTER, 1);
    push(F_G2, 0, 1, 0, 0, 0);
    push(F_G2, 0, 0, 0, 0, 0);
    push(F_G2, 1, 0, 0, 0, 0);
    press(K_TWO, 1);
    wait_for("game2_ready", F_G2, 1, 2000);
    for (int i = 1; i <= 7; i++) begin
      push(F_G2, 0, 1, 0, 4'(i), 0);
      push(F_G2, 0, 0, 0, 4'(i), 0);
      if (i < 7) push(F_G2, 1, 0, 0, 4'(i), 0);
      pulse(1'b0, 1'b1);
      if (i == 1) begin
        pulse(1'b0, 1'b1);
        repeat (3) @(negedge Clk);
        check("countdown_ignores_score", 32'(bus.Score2), 32'd1);
      end
      if (i < 7) wait_for("game2_point_ready", F_G2, 1, 2000);
    end
    // a pending P on the win tick loses to the win
    push(F_EXIT, 0, 0, 0, 7, 2'b10);
    press(K_P, 1);
    wait_for("exit_p2", F_EXIT, 0, 200);
    check("winner_p2", 32'(bus.winner), 32'd2);
    push(F_MAIN, 0, 0, 0, 7, 2'b10);
    press(K_ENTER, 1);
    // GAME1: simultaneous points up to a 7-7 draw
    push(F_START, 0, 0, 0, 7, 2'b10);
    press(K_ENTER, 1);
    push(F_G1, 0, 1, 0, 0, 0);
    push(F_G1, 0, 0, 0, 0, 0);
    push(F_G1, 1, 0, 0, 0, 0);
    press(K_ONE, 1);
    wait_for("game1_ready", F_G1, 1, 2000);
    for (int i = 1; i <= 7; i++) begin
      push(F_G1, 0, 1, 4'(i), 4'(i), 0);
      push(F_G1, 0, 0, 4'(i), 4'(i), 0);
      if (i < 7) push(F_G1, 1, 0, 4'(i), 4'(i), 0);
      pulse(1'b1, 1'b1);
      if (i < 7) wait_for("draw_point_ready", F_G1, 1, 2000);
    end
    push(F_EXIT, 0, 0, 7, 7, 2'b11);
    wait_for("exit_draw", F_EXIT, 0, 200);
    check("winner_draw", 32'(bus.winner), 32'd3);
    push(F_MAIN, 0, 0, 7, 7, 2'b11);
`ifdef SCREEN_EXIT_TIMEOUT_EN
    n = 0;
    while (bus.MainS !== 1'b1 && n < 400) begin
      settle_tick();
      n++;
    end
    check("exit_timeout_ticks", 32'(n), 32'd300);
`else
    press(K_ENTER, 1);
`endif
    // I then ESC inside one frame: first key wins, second is dropped
    push(F_INSTR, 0, 0, 7, 7, 2'b11);
    settle_tick();
    @(negedge Clk) bus.keycode = K_I;
    repeat (2) @(negedge Clk);
    bus.keycode = K_ESC;
    repeat (2) @(negedge Clk);
    bus.keycode = 8'h00;
    repeat (2) settle_tick();
    check("instr_first_key", 32'(cur_flags()), 32'(F_INSTR));
    push(F_MAIN, 0, 0, 7, 7, 2'b11);
    press(K_ESC, 1);
    // async reset in the middle of a countdown
    push(F_START, 0, 0, 7, 7, 2'b11);
    press(K_ENTER, 1);
    push(F_G1, 0, 1, 0, 0, 0);
    push(F_G1, 0, 0, 0, 0, 0);
    press(K_ONE, 1);
    repeat (10) settle_tick();
    check("mid_countdown", 32'({cur_flags(), bus.Ready}), 32'({F_G1, 1'b0}));
    push(F_MAIN, 0, 0, 0, 0, 0);
    #3 Reset_n = 1'b0;
    #1 check("async_reset", 32'({sample(), bus.game_rst}), 32'({20'h80000, 1'b0}));
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) settle_tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
